// File: rtl/fetch_control_if.sv
// Control bundle between the fetch/control sequencer and the datapath it steers.
// master: the sequencer. slave: the PC, memory, register file and flag register side.
interface fetch_control_if;
  logic [15:0] instr_in;
  logic [4:0]  flags;
  logic [15:0] ir;
  logic        pc_en;
  logic        branch;
  logic        jump;
  logic [7:0]  b_offset;
  logic        addr_sel;
  logic        mem_we;
  logic        reg_we;
  logic        wb_sel;
  logic        flags_en;
  logic [1:0]  state;

  modport master (
    input  instr_in, flags,
    output ir, pc_en, branch, jump, b_offset, addr_sel,
           mem_we, reg_we, wb_sel, flags_en, state
  );

  modport slave (
    output instr_in, flags,
    input  ir, pc_en, branch, jump, b_offset, addr_sel,
           mem_we, reg_we, wb_sel, flags_en, state
  );
endinterface

// File: rtl/fetch_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CR16-subset datapath.
// No handshakes: strobes are single-cycle pulses and pc_en fires once, in each instruction's last cycle.
module fetch_control_fsm #(
  parameter logic [15:0] RESET_IR = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  fetch_control_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXEC    = 2'd2,
    S_LOAD_WB = 2'd3
  } state_t;

  state_t      state_q, state_d, cur_state;
  logic [15:0] ir_q, ir_d;

  logic [3:0] op, ext, cond;
  logic       is_bcond, is_jcond, is_load, is_stor, is_nop, is_alu;
  logic       cond_true;
  logic       flag_c, flag_l, flag_f, flag_z, flag_n;

  assign op   = ir_q[15:12];
  assign cond = ir_q[11:8];
  assign ext  = ir_q[7:4];

  assign is_bcond = (op == 4'b1100);
  assign is_jcond = (op == 4'b0100) && (ext == 4'b1100);
  assign is_load  = (op == 4'b0100) && (ext == 4'b0000);
  assign is_stor  = (op == 4'b0100) && (ext == 4'b0100);
  assign is_nop   = (op == 4'b0100) && !is_jcond && !is_load && !is_stor;
  assign is_alu   = !is_bcond && (op != 4'b0100);

  assign {flag_c, flag_l, flag_f, flag_z, flag_n} = bus.flags;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = !flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = !flag_c;
      4'b0100: cond_true = flag_l;
      4'b0101: cond_true = !flag_l;
      4'b0110: cond_true = flag_n;
      4'b0111: cond_true = !flag_n;
      4'b1000: cond_true = flag_f;
      4'b1001: cond_true = !flag_f;
      4'b1010: cond_true = !flag_l && !flag_z;
      4'b1011: cond_true = flag_l || flag_z;
      4'b1100: cond_true = !flag_n && !flag_z;
      4'b1101: cond_true = flag_n || flag_z;
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ir_q    <= ir_d;
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    if (reset) begin
      state_d = S_FETCH;
      ir_d    = RESET_IR;
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          state_d = S_EXEC;
          ir_d    = bus.instr_in;
        end
        S_EXEC:   state_d = is_load ? S_LOAD_WB : S_FETCH;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // While reset is held the outputs look like FETCH, so an interrupted LOAD/STOR strobes nothing.
  assign cur_state = reset ? S_FETCH : state_q;

  always_comb begin
    bus.pc_en    = 1'b0;
    bus.branch   = 1'b0;
    bus.jump     = 1'b0;
    bus.addr_sel = 1'b0;
    bus.mem_we   = 1'b0;
    bus.reg_we   = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.flags_en = 1'b0;
    case (cur_state)
      S_EXEC: begin
        if (is_bcond) begin
          bus.pc_en  = 1'b1;
          bus.branch = cond_true;
        end
        if (is_jcond) begin
          bus.pc_en    = 1'b1;
          bus.jump     = cond_true;
          bus.addr_sel = 1'b1;
        end
        if (is_load) begin
          bus.addr_sel = 1'b1;
        end
        if (is_stor) begin
          bus.addr_sel = 1'b1;
          bus.mem_we   = 1'b1;
          bus.pc_en    = 1'b1;
        end
        if (is_nop) begin
          bus.pc_en = 1'b1;
        end
        if (is_alu) begin
          bus.reg_we   = 1'b1;
          bus.flags_en = 1'b1;
          bus.pc_en    = 1'b1;
        end
      end
      S_LOAD_WB: begin
        bus.reg_we = 1'b1;
        bus.wb_sel = 1'b1;
        bus.pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ir       = ir_q;
  assign bus.b_offset = ir_q[7:0];
  assign bus.state    = cur_state;

endmodule

// File: tb/tb_fetch_control_fsm.sv
// Directed and randomized bench for fetch_control_fsm against an instruction-level reference model.
module tb_fetch_control_fsm;

  logic clk;
  logic reset;
  fetch_control_if bus ();

  fetch_control_fsm #(.RESET_IR(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int completed = 0;
  int pc_pulses = 0;

  // Expected per-cycle vector {state, pc_en, branch, jump, addr_sel, mem_we, reg_we, wb_sel, flags_en}
  logic [9:0] exp_q[$];

  typedef enum {K_ALU, K_BR, K_JMP, K_LOAD, K_STOR, K_NOP} kind_t;

  always @(negedge clk) begin
    #2;
    if (bus.pc_en === 1'b1) pc_pulses++;
  end

  function automatic logic [9:0] vec(input int st, input logic pc, br, jp, as, mw, rw, wb, fe);
    logic [1:0] s;
    s = st[1:0];
    return {s, pc, br, jp, as, mw, rw, wb, fe};
  endfunction

  function automatic kind_t classify(input logic [15:0] instr);
    if (instr[15:12] == 4'hC) return K_BR;
    if (instr[15:12] != 4'h4) return K_ALU;
    if (instr[7:4] == 4'hC) return K_JMP;
    if (instr[7:4] == 4'h0) return K_LOAD;
    if (instr[7:4] == 4'h4) return K_STOR;
    return K_NOP;
  endfunction

  // Even conditions 0..8 test one flag, the following odd one its complement.
  function automatic logic model_cond(input logic [3:0] c, input logic [4:0] f);
    logic cy, l, fl, z, n;
    logic [4:0] single;
    int idx;
    {cy, l, fl, z, n} = f;
    single = {fl, n, l, cy, z};
    idx = int'(c) / 2;
    if (c < 4'd10) return single[idx] ^ c[0];
    case (c)
      4'd10:   return !l && !z;
      4'd11:   return l || z;
      4'd12:   return !n && !z;
      4'd13:   return n || z;
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle(input logic [15:0] din, input logic [4:0] fl, input logic rst, input string tag);
    logic [9:0] obs;
    @(negedge clk);
    reset        = rst;
    bus.instr_in = din;
    bus.flags    = fl;
    #1;
    obs = {bus.state, bus.pc_en, bus.branch, bus.jump, bus.addr_sel,
           bus.mem_we, bus.reg_we, bus.wb_sel, bus.flags_en};
    if (exp_q.size() == 0) check({tag, "_noexp"}, 32'd1, 32'd0);
    else check(tag, {22'd0, obs}, {22'd0, exp_q.pop_front()});
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic [4:0] flg, input string tag);
    kind_t k;
    logic  ct;
    k  = classify(instr);
    ct = model_cond(instr[11:8], flg);
    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    case (k)
      K_ALU:  exp_q.push_back(vec(2, 1, 0, 0, 0, 0, 1, 0, 1));
      K_BR:   exp_q.push_back(vec(2, 1, ct, 0, 0, 0, 0, 0, 0));
      K_JMP:  exp_q.push_back(vec(2, 1, 0, ct, 1, 0, 0, 0, 0));
      K_LOAD: exp_q.push_back(vec(2, 0, 0, 0, 1, 0, 0, 0, 0));
      K_STOR: exp_q.push_back(vec(2, 1, 0, 0, 1, 1, 0, 0, 0));
      default: exp_q.push_back(vec(2, 1, 0, 0, 0, 0, 0, 0, 0));
    endcase
    if (k == K_LOAD) exp_q.push_back(vec(3, 1, 0, 0, 0, 0, 1, 1, 0));
    do_cycle(16'($urandom), 5'($urandom), 1'b0, {tag, "_fetch"});
    do_cycle(instr, 5'($urandom), 1'b0, {tag, "_decode"});
    do_cycle(16'($urandom), flg, 1'b0, {tag, "_exec"});
    check({tag, "_ir"}, {16'd0, bus.ir}, {16'd0, instr});
    check({tag, "_boff"}, {24'd0, bus.b_offset}, {24'd0, instr[7:0]});
    if (k == K_LOAD) begin
      do_cycle(16'($urandom), 5'($urandom), 1'b0, {tag, "_wb"});
      check({tag, "_ir_wb"}, {16'd0, bus.ir}, {16'd0, instr});
    end
    completed++;
  endtask

  initial begin
    logic [15:0] instr;
    logic [3:0]  op;
    reset        = 1'b1;
    bus.instr_in = 16'h0000;
    bus.flags    = 5'd0;

    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_cycle(16'hFFFF, 5'h1F, 1'b1, "rst0");
    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_cycle(16'h4102, 5'h1F, 1'b1, "rst1");
    check("rst_ir", {16'd0, bus.ir}, 32'h0000);

    run_instr(16'h0501, 5'($urandom), "alu");
    run_instr(16'hC0FE, 5'b00010, "beq_taken");
    run_instr(16'hC0FE, 5'b11101, "beq_not");
    run_instr(16'h4EC3, 5'($urandom), "juc");
    run_instr(16'h4FC3, 5'($urandom), "jnever");
    run_instr(16'h4102, 5'($urandom), "load");
    run_instr(16'h4142, 5'($urandom), "stor");
    run_instr(16'h4173, 5'($urandom), "nop");

    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 32; f++) begin
        instr = {4'hC, 4'(c), 8'($urandom)};
        run_instr(instr, 5'(f), "sweep");
      end
    end

    // LOAD interrupted by reset in EXEC: no write-back, back to FETCH with ir cleared.
    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_cycle(16'($urandom), 5'($urandom), 1'b0, "irq_fetch");
    do_cycle(16'h4102, 5'($urandom), 1'b0, "irq_decode");
    do_cycle(16'($urandom), 5'($urandom), 1'b1, "irq_exec_rst");
    do_cycle(16'($urandom), 5'($urandom), 1'b1, "irq_after");
    check("irq_ir", {16'd0, bus.ir}, 32'h0000);
    run_instr(16'h2345, 5'($urandom), "post_rst");

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 2))
        0:       op = 4'hC;
        1:       op = 4'h4;
        default: op = 4'($urandom);
      endcase
      instr = {op, 12'($urandom)};
      if (op == 4'h4 && $urandom_range(0, 1) == 1) instr[7:4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'hC;
      run_instr(instr, 5'($urandom), "rand");
    end

    @(negedge clk);
    #3;
    check("pc_pulses", pc_pulses, completed);
    check("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_control_fsm.md
Name: fetch_control_fsm

Overview:
- Multi-cycle control sequencer for the 16-bit CR16-subset datapath.
- Sits directly upstream of the program counter and drives its pc_en, branch, jump and b_offset controls.
- Fetches each instruction from synchronous-read memory, latches it into the instruction register, evaluates branch/jump conditions against the flag register, and sequences register-file, flag and memory strobes.
- Advances the PC exactly once per instruction.

Parameters:
- RESET_IR, 16'h0000, instruction register value after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- instr_in  in  16  memory read data; valid one cycle after its address is presented.
- flags  in  5  {C,L,F,Z,N} from the flag register.
- ir  out  16  instruction register.
- pc_en  out  1  PC update strobe.
- branch  out  1  PC takes PC + b_offset (valid with pc_en).
- jump  out  1  PC takes the register target (valid with pc_en).
- b_offset  out  8  equals ir[7:0], signed displacement.
- addr_sel  out  1  memory address source: 0 = PC, 1 = register ir[3:0].
- mem_we  out  1  memory write strobe.
- reg_we  out  1  register file write enable.
- wb_sel  out  1  write-back source: 0 = ALU, 1 = memory.
- flags_en  out  1  flag register load.
- state  out  2  current state, for debug.

Behaviour:
- States and encodings:
  - FETCH=0: addr_sel=0, all strobes 0. Next state DECODE.
  - DECODE=1: ir <= instr_in at the end of the cycle. Next state EXEC.
  - EXEC=2: class-dependent outputs (below). Next state FETCH, or LOAD_WB for LOAD.
  - LOAD_WB=3: reg_we=1, wb_sel=1, pc_en=1. Next state FETCH.
- Instruction classes, decoded from ir (op=ir[15:12], ext=ir[7:4], cond=ir[11:8]):
  - Bcond, op=1100: pc_en=1, branch=cond_true.
  - Jcond, op=0100 and ext=1100: pc_en=1, jump=cond_true, addr_sel=1.
  - LOAD, op=0100 and ext=0000: addr_sel=1. No strobes in EXEC.
  - STOR, op=0100 and ext=0100: addr_sel=1, mem_we=1, pc_en=1.
  - Other op=0100: NOP, pc_en=1 only.
  - All remaining opcodes (ALU): reg_we=1, flags_en=1, pc_en=1, wb_sel=0.
- Condition table (cond -> true when):
  - 0000 Z
  - 0001 !Z
  - 0010 C
  - 0011 !C
  - 0100 L
  - 0101 !L
  - 0110 N
  - 0111 !N
  - 1000 F
  - 1001 !F
  - 1010 !L&!Z
  - 1011 L|Z
  - 1100 !N&!Z
  - 1101 N|Z
  - 1110 always
  - 1111 never
- Condition evaluation uses the flags input sampled in EXEC.
- A not-taken Bcond/Jcond still asserts pc_en with branch=jump=0, so the PC increments.
- branch and jump are never asserted together. Both are 0 outside EXEC.
- Latency:
  - ALU, STOR, Bcond, Jcond, NOP: 3 cycles.
  - LOAD: 4 cycles.
- pc_en is high in exactly one cycle per instruction: the last one.
- Branch displacement is relative to the PC of the branch itself. The PC has not yet advanced when pc_en fires.
- Outputs are decoded combinationally from state and ir. No output depends on instr_in directly.
- Reset:
  - Any state returns to FETCH on the next edge.
  - ir <= RESET_IR.
  - Outputs in the reset cycle follow FETCH: all strobes 0, addr_sel=0.
  - A LOAD or STOR interrupted by reset issues no further reg_we or mem_we.
- b_offset = ir[7:0] at all times. It is meaningful only when branch=1.

Test Plan:
- Reset, then memory returns 16'h0501 (ALU) → state sequence 0,1,2,0; in cycle 2, reg_we=flags_en=pc_en=1 and branch=jump=mem_we=0; ir=16'h0501 from cycle 2.
- Bcond ir=16'hC0FE (EQ, -2) with Z=1 → EXEC: pc_en=1, branch=1, b_offset=8'hFE. Same instruction with Z=0 → pc_en=1, branch=0.
- Jcond ir=16'h4EC3 (UC, R3) → EXEC: pc_en=1, jump=1, addr_sel=1. Jcond with cond=1111 → jump=0, pc_en=1.
- LOAD ir=16'h4102 → EXEC: addr_sel=1 with all strobes 0; LOAD_WB: reg_we=1, wb_sel=1, pc_en=1; 4-cycle latency checked. STOR ir=16'h4142 → EXEC: mem_we=1, addr_sel=1, pc_en=1.
- Sweep all 16 conditions × all 32 flag combinations on Bcond → branch matches the condition table exactly.
- Assert reset during a LOAD's EXEC → next cycle state=FETCH, ir=16'h0000, no reg_we pulse; over the whole run, count of pc_en pulses = count of completed instructions.
